tft_bus_master: RTL and testbench

Host-side initiator for the 8080-style parallel bus (CS, RS, WR, RD, 16-bit DATA) through which the CPLD TFT controller receives register indices, register values, pixel writes and pixel reads. Sits between an on-board command source (MCU bridge or test sequencer) and the controller's bus pins. It turns queued commands into correctly timed index and data phases, and returns read-back words on a single-cycle strobe.

---
 rtl/tft_bus_pkg.sv | 46 ++++
 rtl/tft_bus_phase_timer.sv | 27 ++
 rtl/tft_bus_master.sv | 197 +++++++++++++++++++
 tb/tb_tft_bus_master.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tft_bus_pkg.sv
// Shared types and timing defaults for the 8080-style TFT bus initiator.
package tft_bus_pkg;

  localparam int unsigned BUS_W = 16;
  localparam int unsigned TMR_W = 4;

  localparam int unsigned DEF_SETUP_CYC  = 2;
  localparam int unsigned DEF_STROBE_CYC = 3;
  localparam int unsigned DEF_HOLD_CYC   = 2;
  localparam int unsigned DEF_GAP_CYC    = 3;

  typedef logic [BUS_W-1:0] bus_word_t;

  typedef enum logic [1:0] {
    OP_REG_WR = 2'b00,
    OP_DAT_WR = 2'b01,
    OP_DAT_RD = 2'b10,
    OP_RSVD   = 2'b11
  } op_e;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    IDX_SETUP  = 4'd1,
    IDX_STROBE = 4'd2,
    IDX_HOLD   = 4'd3,
    DAT_WAIT   = 4'd4,
    DAT_SETUP  = 4'd5,
    DAT_STROBE = 4'd6,
    DAT_HOLD   = 4'd7,
    CS_END     = 4'd8,
    GAP        = 4'd9,
    ERR        = 4'd10
  } state_e;

  typedef struct packed {
    op_e       op;
    bus_word_t idx;
    bus_word_t len;
  } cmd_t;

  // Phase timer counts down to zero, so a phase of N cycles loads N-1.
  function automatic logic [TMR_W-1:0] tmr_load(input int unsigned cyc);
    return TMR_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/tft_bus_phase_timer.sv
// Down-counter timing one bus phase; done is high in the last cycle of the phase.
module tft_bus_phase_timer
  import tft_bus_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             done
);

  logic [TMR_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      done <= 1'b1;
    end else if (load) begin
      cnt  <= load_val;
      done <= (load_val == '0);
    end else if (cnt != '0) begin
      cnt  <= cnt - TMR_W'(1);
      done <= (cnt == TMR_W'(1));
    end
  end

endmodule

// File: rtl/tft_bus_master.sv
// Host-side initiator for the TFT controller's CS/RS/WR/RD parallel bus.
// Read bursts and read-back capture exist only when TFT_BUS_READ_EN is defined.
module tft_bus_master
  import tft_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = DEF_SETUP_CYC,
  parameter int unsigned STROBE_CYC = DEF_STROBE_CYC,
  parameter int unsigned HOLD_CYC   = DEF_HOLD_CYC,
  parameter int unsigned GAP_CYC    = DEF_GAP_CYC
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_reg,
  input  logic [15:0] cmd_len,
  input  logic [15:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        err,
  output logic        CS,
  output logic        RS,
  output logic        WR,
  output logic        RD,
  output logic [15:0] DATA_O,
  input  logic [15:0] DATA_I,
  output logic        DATA_OE
);

  localparam logic [TMR_W-1:0] SETUP_LD  = tmr_load(SETUP_CYC);
  localparam logic [TMR_W-1:0] STROBE_LD = tmr_load(STROBE_CYC);
  localparam logic [TMR_W-1:0] HOLD_LD   = tmr_load(HOLD_CYC);
  localparam logic [TMR_W-1:0] GAP_LD    = tmr_load(GAP_CYC);

  state_e           state, state_d;
  cmd_t             cmd_q, cmd_d;
  bus_word_t        words_q, words_d;
  bus_word_t        data_o_d;
  logic             cs_d, rs_d, wr_d, rd_d, oe_d;
  logic             cmd_ready_d, wr_ready_d, busy_d, err_d;
  logic             op_ok_c, is_rd_c, idx_ph_c, dat_ph_c, rd_capture_c;
  logic             tmr_load_c, phase_done;
  logic [TMR_W-1:0] tmr_val_c;

  tft_bus_phase_timer u_timer (
    .clk      (clk),
    .rst_n    (RST),
    .load     (tmr_load_c),
    .load_val (tmr_val_c),
    .done     (phase_done)
  );

  // Ops this build can execute; anything else is rejected with err.
  always_comb begin
    op_ok_c = 1'b0;
`ifdef TFT_BUS_READ_EN
    op_ok_c = (cmd_op != OP_RSVD);
`else
    op_ok_c = (cmd_op == OP_REG_WR) || (cmd_op == OP_DAT_WR);
`endif
  end

  // Next state, command context and next values of all registered outputs.
  always_comb begin
    state_d      = state;
    cmd_d        = cmd_q;
    words_d      = words_q;
    data_o_d     = DATA_O;
    rd_capture_c = 1'b0;

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cmd_d.op  = op_e'(cmd_op);
          cmd_d.idx = cmd_reg;
          cmd_d.len = cmd_len;
          state_d   = op_ok_c ? IDX_SETUP : ERR;
        end
      end
      IDX_SETUP:  if (phase_done) state_d = IDX_STROBE;
      IDX_STROBE: if (phase_done) state_d = IDX_HOLD;
      IDX_HOLD: begin
        if (phase_done) begin
          words_d = (cmd_q.op == OP_REG_WR) ? 16'd1 : cmd_q.len;
          state_d = (words_d == '0) ? CS_END : DAT_WAIT;
        end
      end
      DAT_WAIT: begin
        if (cmd_q.op == OP_DAT_RD) begin
          state_d = DAT_SETUP;
        end else if (wr_valid && wr_ready) begin
          data_o_d = wr_data;
          state_d  = DAT_SETUP;
        end
      end
      DAT_SETUP: if (phase_done) state_d = DAT_STROBE;
      DAT_STROBE: begin
        if (phase_done) begin
          rd_capture_c = (cmd_q.op == OP_DAT_RD);
          state_d      = DAT_HOLD;
        end
      end
      DAT_HOLD: begin
        if (phase_done) begin
          words_d = words_q - 16'd1;
          state_d = (words_q == 16'd1) ? CS_END : DAT_WAIT;
        end
      end
      CS_END:  state_d = GAP;
      GAP:     if (phase_done) state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    idx_ph_c = (state_d == IDX_SETUP) || (state_d == IDX_STROBE) || (state_d == IDX_HOLD);
    dat_ph_c = (state_d == DAT_WAIT) || (state_d == DAT_SETUP) ||
               (state_d == DAT_STROBE) || (state_d == DAT_HOLD);
    is_rd_c  = (cmd_d.op == OP_DAT_RD);

    if (idx_ph_c) data_o_d = cmd_d.idx;

    cs_d        = !(idx_ph_c || dat_ph_c);
    rs_d        = !idx_ph_c;
    wr_d        = !((state_d == IDX_STROBE) || ((state_d == DAT_STROBE) && !is_rd_c));
    rd_d        = !((state_d == DAT_STROBE) && is_rd_c);
    oe_d        = idx_ph_c || (dat_ph_c && !is_rd_c);
    cmd_ready_d = (state_d == IDLE);
    wr_ready_d  = (state_d == DAT_WAIT) && !is_rd_c;
    busy_d      = (state_d != IDLE);
    err_d       = (state_d == ERR);

    tmr_load_c = (state_d != state);
    case (state_d)
      IDX_SETUP, DAT_SETUP:   tmr_val_c = SETUP_LD;
      IDX_STROBE, DAT_STROBE: tmr_val_c = STROBE_LD;
      IDX_HOLD, DAT_HOLD:     tmr_val_c = HOLD_LD;
      GAP:                    tmr_val_c = GAP_LD;
      default:                tmr_val_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      cmd_q     <= '0;
      words_q   <= '0;
      CS        <= 1'b1;
      RS        <= 1'b1;
      WR        <= 1'b1;
      DATA_O    <= '0;
      DATA_OE   <= 1'b0;
      cmd_ready <= 1'b0;
      wr_ready  <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      cmd_q     <= cmd_d;
      words_q   <= words_d;
      CS        <= cs_d;
      RS        <= rs_d;
      WR        <= wr_d;
      DATA_O    <= data_o_d;
      DATA_OE   <= oe_d;
      cmd_ready <= cmd_ready_d;
      wr_ready  <= wr_ready_d;
      busy      <= busy_d;
      err       <= err_d;
    end
  end

`ifdef TFT_BUS_READ_EN
  // Read strobe and read-back word, captured on the last strobe cycle.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      RD       <= 1'b1;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      RD       <= rd_d;
      rd_valid <= rd_capture_c;
      if (rd_capture_c) rd_data <= DATA_I;
    end
  end
`else
  logic unused_read;
  assign unused_read = ^{DATA_I, rd_d, rd_capture_c};
  assign RD          = 1'b1;
  assign rd_valid    = 1'b0;
  assign rd_data     = '0;
`endif

endmodule

// File: tb/tb_tft_bus_master.sv
// Directed bench for tft_bus_master: bus monitor plus hand-computed expectations.
// Read-burst checks apply when TFT_BUS_READ_EN is defined, else op 10 must be rejected.
module tb_tft_bus_master;

  localparam int STROBE = 3;

  logic        clk;
  logic        RST;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_reg, cmd_len;
  logic [15:0] wr_data;
  logic        wr_valid, wr_ready;
  logic [15:0] rd_data;
  logic        rd_valid, busy, err;
  logic        CS, RS, WR, RD;
  logic [15:0] DATA_O, DATA_I;
  logic        DATA_OE;

  tft_bus_master dut (
    .clk(clk), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_reg(cmd_reg), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .err(err),
    .CS(CS), .RS(RS), .WR(WR), .RD(RD),
    .DATA_O(DATA_O), .DATA_I(DATA_I), .DATA_OE(DATA_OE)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Write-data source
  int          wr_total = 0;
  int          wr_sent  = 0;
  logic [15:0] wr_base  = '0;
  bit          wr_gaps  = 1'b0;
  bit          wr_clear = 1'b0;

  always @(negedge clk) begin
    wr_valid = (wr_sent < wr_total) && (!wr_gaps || ($urandom_range(0, 3) != 0));
    wr_data  = wr_base + 16'(wr_sent);
  end

  always @(posedge clk) begin
    if (wr_clear) wr_sent = 0;
    else if (wr_valid && wr_ready) wr_sent++;
  end

  // Bus monitor, sampled on the falling edge
  logic [16:0] wr_log[$];
  logic [15:0] rd_log[$];
  int  wr_low = 0, rd_low = 0;
  int  wr_len_bad = 0, rd_len_bad = 0, rd_pulses = 0, rd_oe_bad = 0, rd_seen = 0;
  int  cs_falls = 0, cs_low = 0, err_seen = 0, stall_bad = 0, strobe_cs_bad = 0;
  bit  mon_clear = 1'b0;
  logic prev_wr = 1'b1, prev_rd = 1'b1, prev_cs = 1'b1, prev_oe = 1'b0;

  always @(negedge clk) begin
    if (mon_clear) begin
      wr_log.delete();
      rd_log.delete();
      wr_low = 0; rd_low = 0; wr_len_bad = 0; rd_len_bad = 0; rd_pulses = 0;
      rd_oe_bad = 0; rd_seen = 0; cs_falls = 0; cs_low = 0; err_seen = 0;
      stall_bad = 0; strobe_cs_bad = 0;
    end else begin
      if (prev_wr && !WR) wr_log.push_back({RS, DATA_O});
      if (!WR) wr_low++;
      else begin
        if (!prev_wr && wr_low != STROBE) wr_len_bad++;
        wr_low = 0;
      end
      if (prev_rd && !RD) begin
        DATA_I = 16'hA500 + 16'(rd_pulses);
        rd_pulses++;
        if (prev_oe) rd_oe_bad++;
      end
      if (!RD) begin
        rd_low++;
        rd_seen++;
        if (DATA_OE) rd_oe_bad++;
      end else begin
        if (!prev_rd && rd_low != STROBE) rd_len_bad++;
        rd_low = 0;
      end
      if (rd_valid) rd_log.push_back(rd_data);
      if (prev_cs && !CS) cs_falls++;
      if (!CS) cs_low++;
      if (err) err_seen++;
      if (wr_ready && (!WR || CS)) stall_bad++;
      if ((!WR || !RD) && CS) strobe_cs_bad++;
    end
    prev_wr = WR; prev_rd = RD; prev_cs = CS; prev_oe = DATA_OE;
  end

  task automatic clear_logs();
    @(posedge clk); #1;
    mon_clear = 1'b1; wr_clear = 1'b1;
    @(posedge clk); #1;
    mon_clear = 1'b0; wr_clear = 1'b0;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [15:0] idx,
                          input logic [15:0] len, input bit expect_err);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", 32'(cmd_ready), 32'(1));
    cmd_op = op; cmd_reg = idx; cmd_len = len; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    if (expect_err) begin
      check("err_pulse_lat", 32'(err), 32'(1));
      check("err_cs_high", 32'(CS), 32'(1));
    end else begin
      check("cs_fall_lat", 32'(CS), 32'(0));
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while (!(cmd_ready && !busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check("idle_timeout", 32'(cmd_ready && !busy), 32'(1));
  endtask

  task automatic check_wr_log(input string tag, input logic [15:0] idx,
                              input logic [15:0] base, input int nwords);
    check({tag, "_wr_count"}, 32'(wr_log.size()), 32'(nwords + 1));
    if (wr_log.size() == nwords + 1) begin
      check({tag, "_idx"}, 32'(wr_log[0]), 32'({1'b0, idx}));
      for (int i = 0; i < nwords; i++)
        check({tag, "_word"}, 32'(wr_log[i+1]), 32'({1'b1, base + 16'(i)}));
    end
  endtask

  initial begin
    RST = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_reg = '0; cmd_len = '0; DATA_I = '0;
    #15;
    check("rst_cs", 32'(CS), 32'(1));
    check("rst_rs", 32'(RS), 32'(1));
    check("rst_wr", 32'(WR), 32'(1));
    check("rst_rd", 32'(RD), 32'(1));
    check("rst_oe", 32'(DATA_OE), 32'(0));
    check("rst_data_o", 32'(DATA_O), 32'(0));
    check("rst_cmd_ready", 32'(cmd_ready), 32'(0));
    check("rst_wr_ready", 32'(wr_ready), 32'(0));
    check("rst_rd_valid", 32'(rd_valid), 32'(0));
    check("rst_rd_data", 32'(rd_data), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    @(negedge clk);
    RST = 1'b1;
    #1 check("cmd_ready_pre_edge", 32'(cmd_ready), 32'(0));
    @(negedge clk);
    check("cmd_ready_first_clk", 32'(cmd_ready), 32'(1));

    // Op 00: index 0x0001 then data 0x0002; CS low 7 + 8 = 15 cycles
    clear_logs();
    wr_base = 16'h0002; wr_total = 1; wr_gaps = 1'b0;
    send_cmd(2'b00, 16'h0001, 16'hFFFF, 1'b0);
    wait_idle(200);
    check_wr_log("op00", 16'h0001, 16'h0002, 1);
    check("op00_wr_len", 32'(wr_len_bad), 32'(0));
    check("op00_cs_falls", 32'(cs_falls), 32'(1));
    check("op00_cs_low", 32'(cs_low), 32'(15));

    // Op 01 burst of 50 with random wr_valid gaps
    clear_logs();
    wr_base = 16'h001F; wr_total = 50; wr_gaps = 1'b1;
    send_cmd(2'b01, 16'h000F, 16'd50, 1'b0);
    wait_idle(5000);
    check_wr_log("burst", 16'h000F, 16'h001F, 50);
    check("burst_wr_len", 32'(wr_len_bad), 32'(0));
    check("burst_stall", 32'(stall_bad), 32'(0));
    check("burst_cs_falls", 32'(cs_falls), 32'(1));
    check("burst_strobe_cs", 32'(strobe_cs_bad), 32'(0));

`ifdef TFT_BUS_READ_EN
    // Op 10 burst of 10 reads
    clear_logs();
    wr_total = 0; wr_gaps = 1'b0;
    send_cmd(2'b10, 16'h000F, 16'd10, 1'b0);
    wait_idle(1000);
    check_wr_log("rd_idx", 16'h000F, 16'h0000, 0);
    check("rd_pulses", 32'(rd_pulses), 32'(10));
    check("rd_len", 32'(rd_len_bad), 32'(0));
    check("rd_oe", 32'(rd_oe_bad), 32'(0));
    check("rd_valid_count", 32'(rd_log.size()), 32'(10));
    if (rd_log.size() == 10)
      for (int i = 0; i < 10; i++)
        check("rd_word", 32'(rd_log[i]), 32'(16'hA500 + 16'(i)));
    check("rd_cs_falls", 32'(cs_falls), 32'(1));
`else
    // Op 10 is rejected in this build
    clear_logs();
    wr_total = 0; wr_gaps = 1'b0;
    send_cmd(2'b10, 16'h000F, 16'd10, 1'b1);
    @(negedge clk);
    check("rd_rej_idle", 32'(cmd_ready), 32'(1));
    check("rd_rej_err_low", 32'(err), 32'(0));
    wait_idle(50);
    check("rd_rej_err_cnt", 32'(err_seen), 32'(1));
    check("rd_rej_rd_high", 32'(rd_seen), 32'(0));
    check("rd_rej_cs", 32'(cs_falls), 32'(0));
    check("rd_rej_rd_valid", 32'(rd_log.size()), 32'(0));
`endif

    // Op 01 with length 0: index phase only, 7 cycles of CS low
    clear_logs();
    send_cmd(2'b01, 16'h0033, 16'd0, 1'b0);
    wait_idle(200);
    check_wr_log("len0", 16'h0033, 16'h0000, 0);
    check("len0_cs_low", 32'(cs_low), 32'(7));
    check("len0_cs_falls", 32'(cs_falls), 32'(1));

    // Op 11: err pulse, back to IDLE next cycle, no bus activity
    clear_logs();
    send_cmd(2'b11, 16'h1234, 16'd4, 1'b1);
    @(negedge clk);
    check("op11_idle", 32'(cmd_ready), 32'(1));
    check("op11_err_low", 32'(err), 32'(0));
    wait_idle(50);
    check("op11_err_cnt", 32'(err_seen), 32'(1));
    check("op11_cs", 32'(cs_falls), 32'(0));

    // Reset during the 3rd data word of a write burst
    clear_logs();
    wr_base = 16'h0100; wr_total = 8; wr_gaps = 1'b0;
    send_cmd(2'b01, 16'h0020, 16'd8, 1'b0);
    begin
      int n = 0;
      while (wr_log.size() < 4 && n < 500) begin
        @(negedge clk);
        n++;
      end
      check("rst_mid_reached", 32'(wr_log.size() >= 4), 32'(1));
    end
    #3 RST = 1'b0;
    wr_total = 0;
    #1;
    check("rst_mid_cs", 32'(CS), 32'(1));
    check("rst_mid_wr", 32'(WR), 32'(1));
    check("rst_mid_rd", 32'(RD), 32'(1));
    check("rst_mid_oe", 32'(DATA_OE), 32'(0));
    check("rst_mid_busy", 32'(busy), 32'(0));
    @(negedge clk);
    RST = 1'b1;

    // Fresh op 00 after the aborted burst
    clear_logs();
    wr_base = 16'h0066; wr_total = 1; wr_gaps = 1'b0;
    send_cmd(2'b00, 16'h0055, 16'd0, 1'b0);
    wait_idle(200);
    check_wr_log("post_rst", 16'h0055, 16'h0066, 1);
    check("post_rst_cs_low", 32'(cs_low), 32'(15));
    check("post_rst_wr_len", 32'(wr_len_bad), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
